mul_sequencer: RTL and testbench
================================

// Module: mul_sequencer
// PURPOSE
//   Multi-cycle controller for the EX-stage MUL operation (ALU control code 4'b0101).
//   Decodes a MUL in EX and runs an iterative shift-add multiplier, one multiplier bit per cycle.
//   Stalls IF/ID/EX until the product is ready, then presents the low DATA_W bits of the product
//   to the EX result mux for one cycle.
// PARAMETERS
//   DATA_W       32       operand/result width; product truncated to DATA_W bits (RV32 MUL semantics)
//   ALUCTRL_W    4        width of ALU control code
// PORTS
//   clk_i           in   1          clock, all state updates on rising edge
//   rst_i           in   1          reset, synchronous, active-high
//   valid_i         in   1          EX stage holds a valid instruction
//   ALUCtrl_i       in   ALUCTRL_W  ALU control code of EX instruction
//   rs1_data_i      in   DATA_W     multiplicand
//   rs2_data_i      in   DATA_W     multiplier
//   flush_i         in   1          kill in-flight MUL (branch taken / exception)
//   stall_o         out  1          hold IF/ID/EX pipeline registers
//   busy_o          out  1          sequencer in BUSY state
//   result_valid_o  out  1          result_o valid this cycle (one-cycle pulse)
//   result_o        out  DATA_W     product[DATA_W-1:0], registered
// BEHAVIOUR
//   - States: IDLE, BUSY, DONE. start = valid_i & (ALUCtrl_i==ALUCTRL_MUL) & ~flush_i.
//   - Reset (rst_i=1 at edge): state=IDLE, acc/mcand/mplier/count=0, result_o=0;
//     stall_o=0, busy_o=0, result_valid_o=0.
//   - IDLE: on start -> BUSY; load mcand=rs1_data_i, mplier=rs2_data_i, acc=0, count=DATA_W.
//   - BUSY, each cycle: if mplier[0], acc+=mcand (mod 2^DATA_W); mcand<<=1; mplier>>=1; count-=1.
//     Transition to DONE on the cycle in which count goes 1->0.
//   - Entering DONE: result_o <= final acc. result_o holds that value until the next DONE.
//   - DONE: result_valid_o=1, stall_o=0. Unconditionally -> IDLE. start is ignored in DONE,
//     so the MUL still in EX is not re-issued.
//   - stall_o = (IDLE & start) | BUSY (combinational). busy_o = BUSY.
//   - Latency: start accepted cycle 0, BUSY cycles 1..DATA_W, DONE at cycle DATA_W+1.
//     stall_o is high for cycles 0..DATA_W.
//   - Signed/unsigned: no sign handling; the low DATA_W bits are identical for both.
//   - flush_i: in any state, next state=IDLE. No result_valid_o pulse. result_o unchanged.
//     stall_o drops the cycle after flush. flush_i has priority over start and over BUSY->DONE.
//   - rst_i has priority over flush_i and start. Reset mid-BUSY discards the operation.
//   - Non-MUL ALUCtrl_i, or valid_i=0: no state change, stall_o=0.
// CONFIGURATION
//   - MUL_EARLY_TERM_EN defined: in BUSY, if mplier==0 at the start of the cycle, skip the step
//     and go to DONE next cycle (acc unchanged). Minimum latency is one BUSY cycle;
//     stall_o deasserts accordingly.
//   - MUL_EARLY_TERM_EN undefined: always exactly DATA_W BUSY cycles, independent of data.
// STRUCTURE
//   - Package mul_seq_pkg:
//     - state enum {IDLE, BUSY, DONE}
//     - ALUCTRL_MUL = 4'b0101 and the other ALU control codes (AND 0000, XOR 0001, SLL 0010,
//       ADD 0011, SUB 0100, ADDI 0110, SRAI 0111, LW/SW 1000, BEQ 1001)
//     - counter width CNT_W = $clog2(DATA_W+1)
//   - Sub-module mul_step_datapath: acc/mcand/mplier registers with load, step and hold controls,
//     plus mplier_zero flag. The FSM, counter and stall logic live in mul_sequencer.
// TESTING
//   1. rs1=7, rs2=6, start at cycle 0 -> stall_o high cycles 0..32;
//      result_valid_o=1 at cycle 33 with result_o=42; stall_o=0 at cycle 33.
//   2. 0xFFFFFFFF*0xFFFFFFFF -> result_o=0x00000001; 0xFFFFFFFD*5 -> 0xFFFFFFF1.
//   3. rs1=9, rs2=9, flush_i=1 at cycle 10 -> IDLE at cycle 11, stall_o=0, no result_valid_o,
//      result_o keeps its previous value.
//   4. rst_i=1 at cycle 15 of a MUL -> cycle 16: stall_o=busy_o=result_valid_o=0, result_o=0.
//      A new MUL at cycle 17 completes normally at cycle 50.
//   5. valid_i=1, ALUCtrl_i=4'b0011 (ADD) held 5 cycles -> stall_o=0 and busy_o=0 throughout.
//      MUL held in EX across DONE -> exactly one result_valid_o pulse.
//   6. With MUL_EARLY_TERM_EN: 123*0 -> DONE at cycle 2, result 0; 5*1 -> DONE at cycle 3,
//      result 5. Without the macro: both reach DONE at cycle 33 with the same results.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the EX-stage MUL sequencer.
//   state_t       : sequencer FSM states (IDLE, BUSY, DONE)
//   ALUCTRL_*     : ALU control codes decoded in EX; only ALUCTRL_MUL starts the sequencer
//   CNT_W         : step counter width for the default 32-bit datapath
//   cnt_width()   : counter width for an arbitrary operand width (must hold DATA_W itself)
package mul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] ALUCTRL_AND  = 4'b0000;
  localparam logic [3:0] ALUCTRL_XOR  = 4'b0001;
  localparam logic [3:0] ALUCTRL_SLL  = 4'b0010;
  localparam logic [3:0] ALUCTRL_ADD  = 4'b0011;
  localparam logic [3:0] ALUCTRL_SUB  = 4'b0100;
  localparam logic [3:0] ALUCTRL_MUL  = 4'b0101;
  localparam logic [3:0] ALUCTRL_ADDI = 4'b0110;
  localparam logic [3:0] ALUCTRL_SRAI = 4'b0111;
  localparam logic [3:0] ALUCTRL_LWSW = 4'b1000;
  localparam logic [3:0] ALUCTRL_BEQ  = 4'b1001;

  localparam int MUL_DATA_W = 32;
  localparam int CNT_W      = $clog2(MUL_DATA_W + 1);

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mul_step_datapath.sv
// Shift-add multiplier datapath: one multiplier bit consumed per step.
// Ports:
//   clk, rst        clock / synchronous active-high reset (clears all registers)
//   load            capture operands, clear accumulator
//   step            perform one shift-add iteration (otherwise registers hold)
//   mcand_in        multiplicand to load
//   mplier_in       multiplier to load
//   acc             current accumulator (product modulo 2^DATA_W)
//   acc_next        accumulator value after this cycle's step (equals acc when not stepping)
//   mplier_zero     all remaining multiplier bits are zero
module mul_step_datapath
  import mul_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] mcand_in,
  input  logic [DATA_W-1:0] mplier_in,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] acc_next,
  output logic              mplier_zero
);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;

  // Additions wrap: only the low DATA_W product bits are ever needed,
  // and those are identical for signed and unsigned operands.
  always_comb begin
    acc_next = acc;
    if (step && mplier[0]) acc_next = acc + mcand;
  end

  assign mplier_zero = (mplier == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= mcand_in;
      mplier <= mplier_in;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle controller for the EX-stage MUL (ALU control 4'b0101).
// Runs an iterative shift-add multiply, stalls IF/ID/EX while it runs and
// presents the low DATA_W product bits for one cycle in DONE.
// Optional build macro: MUL_EARLY_TERM_EN -- finish as soon as the remaining
// multiplier bits are all zero (at least one BUSY cycle).
// Ports:
//   clk_i, rst_i      clock / synchronous active-high reset
//   valid_i           EX holds a valid instruction
//   ALUCtrl_i         ALU control code of the EX instruction
//   rs1_data_i        multiplicand
//   rs2_data_i        multiplier
//   flush_i           kill any in-flight MUL
//   stall_o           hold IF/ID/EX pipeline registers
//   busy_o            sequencer is in BUSY
//   result_valid_o    one-cycle pulse, result_o valid
//   result_o          registered product[DATA_W-1:0]
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ALUCTRL_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [ALUCTRL_W-1:0] ALUCtrl_i,
  input  logic [DATA_W-1:0]    rs1_data_i,
  input  logic [DATA_W-1:0]    rs2_data_i,
  input  logic                 flush_i,
  output logic                 stall_o,
  output logic                 busy_o,
  output logic                 result_valid_o,
  output logic [DATA_W-1:0]    result_o
);

  localparam int CW = cnt_width(DATA_W);

  state_t          state, state_next;
  logic [CW-1:0]   count, count_next;
  logic            start;
  logic            load, step, result_load;
  logic [DATA_W-1:0] acc, acc_next;
  logic            mplier_zero;

  assign start = valid_i & (ALUCtrl_i == ALUCTRL_W'(ALUCTRL_MUL)) & ~flush_i;

  mul_step_datapath #(.DATA_W(DATA_W)) u_datapath (
    .clk        (clk_i),
    .rst        (rst_i),
    .load       (load),
    .step       (step),
    .mcand_in   (rs1_data_i),
    .mplier_in  (rs2_data_i),
    .acc        (acc),
    .acc_next   (acc_next),
    .mplier_zero(mplier_zero)
  );

`ifndef MUL_EARLY_TERM_EN
  // Fixed-latency build: the zero flag and the registered accumulator are not consulted.
  logic unused_dp;
  assign unused_dp = mplier_zero ^ (^acc);
`else
  logic unused_dp;
  assign unused_dp = ^acc;
`endif

  always_comb begin
    state_next     = state;
    count_next     = count;
    load           = 1'b0;
    step           = 1'b0;
    result_load    = 1'b0;
    stall_o        = 1'b0;
    busy_o         = 1'b0;
    result_valid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_BUSY;
          count_next = CW'(DATA_W);
          load       = 1'b1;
          stall_o    = 1'b1;
        end
      end
      ST_BUSY: begin
        busy_o  = 1'b1;
        stall_o = 1'b1;
`ifdef MUL_EARLY_TERM_EN
        if (mplier_zero) begin
          state_next  = ST_DONE;
          result_load = 1'b1;
        end else
`endif
        begin
          step       = 1'b1;
          count_next = count - CW'(1);
          // The step taken on the last count produces the final product,
          // so result_o captures acc_next rather than acc.
          if (count == CW'(1)) begin
            state_next  = ST_DONE;
            result_load = 1'b1;
          end
        end
      end
      ST_DONE: begin
        // start is ignored here so the MUL still sitting in EX is not re-issued.
        result_valid_o = 1'b1;
        state_next     = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // Flush beats both start and BUSY->DONE; stall_o still reflects the current state.
    if (flush_i) begin
      state_next  = ST_IDLE;
      load        = 1'b0;
      step        = 1'b0;
      result_load = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      count    <= '0;
      result_o <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (result_load) result_o <= acc_next;
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed testbench for mul_sequencer: latency, products, flush, reset,
// non-MUL codes and the one-pulse-per-MUL behaviour. Build with
// MUL_EARLY_TERM_EN defined to expect the data-dependent latency.
module tb_mul_sequencer;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [3:0]  alu_ctrl;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_ADD = 4'b0011;

  mul_sequencer #(.DATA_W(32), .ALUCTRL_W(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .valid_i       (valid),
    .ALUCtrl_i     (alu_ctrl),
    .rs1_data_i    (rs1),
    .rs2_data_i    (rs2),
    .flush_i       (flush),
    .stall_o       (stall),
    .busy_o        (busy),
    .result_valid_o(result_valid),
    .result_o      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance into the next cycle; inputs change just after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Cycle (relative to start) at which DONE is expected.
  function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return (n == 32) ? 33 : n + 2;
`else
    return (b === 32'hx) ? 0 : 33;
`endif
  endfunction

  // Issue a MUL at cycle 0, hold it in EX through DONE, then retire it.
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int   cyc;
    logic stall_all;
    logic busy_all;
    next_cycle();
    valid = 1'b1; alu_ctrl = OP_MUL; rs1 = a; rs2 = b;
    @(negedge clk);
    cyc       = 0;
    stall_all = stall;
    busy_all  = 1'b1;
    check({tag, "_busy_c0"}, 32'(busy), 32'd0);
    while (result_valid !== 1'b1 && cyc < 40) begin
      next_cycle();
      @(negedge clk);
      cyc++;
      if (result_valid !== 1'b1) begin
        stall_all = stall_all & stall;
        busy_all  = busy_all & busy;
      end
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'(lat));
    check({tag, "_result"}, result, exp);
    check({tag, "_stall_done"}, 32'(stall), 32'd0);
    check({tag, "_stall_run"}, 32'(stall_all), 32'd1);
    check({tag, "_busy_run"}, 32'(busy_all), 32'd1);
    next_cycle();
    valid = 1'b0; alu_ctrl = OP_ADD;
    @(negedge clk);
    check({tag, "_single_pulse"}, 32'(result_valid), 32'd0);
    check({tag, "_no_reissue"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic any_pulse;
    rst = 1'b1; valid = 1'b0; alu_ctrl = 4'b0000; rs1 = '0; rs2 = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rvalid", 32'(result_valid), 32'd0);
    check("reset_result", result, 32'd0);

    // Basic products and latency
    do_mul("mul_7x6", 32'd7, 32'd6, 32'd42, exp_lat(32'd6));
    do_mul("mul_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, exp_lat(32'hFFFF_FFFF));
    do_mul("mul_neg3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, exp_lat(32'd5));

    // Flush at cycle 10 of a 9*9
    next_cycle();
    valid = 1'b1; alu_ctrl = OP_MUL; rs1 = 32'd9; rs2 = 32'd9;
    @(negedge clk);
    check("flush_stall_c0", 32'(stall), 32'd1);
    for (int i = 1; i <= 9; i++) begin
      next_cycle();
      @(negedge clk);
    end
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy_c10", 32'(busy), 32'd1);
    next_cycle();
    flush = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("flush_stall_c11", 32'(stall), 32'd0);
    check("flush_busy_c11", 32'(busy), 32'd0);
    check("flush_rvalid_c11", 32'(result_valid), 32'd0);
    check("flush_result_kept", result, 32'hFFFF_FFF1);
    any_pulse = 1'b0;
    for (int i = 0; i < 30; i++) begin
      next_cycle();
      @(negedge clk);
      any_pulse = any_pulse | result_valid;
    end
    check("flush_no_pulse", 32'(any_pulse), 32'd0);
    check("flush_result_later", result, 32'hFFFF_FFF1);

    // Reset at cycle 15 of a 3*4, new MUL at cycle 17
    next_cycle();
    valid = 1'b1; alu_ctrl = OP_MUL; rs1 = 32'd3; rs2 = 32'd4;
    @(negedge clk);
    for (int i = 1; i <= 14; i++) begin
      next_cycle();
      @(negedge clk);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    next_cycle();
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_rvalid", 32'(result_valid), 32'd0);
    check("rst_mid_result", result, 32'd0);
    do_mul("after_rst_11x13", 32'd11, 32'd13, 32'd143, exp_lat(32'd13));

    // Non-MUL instruction held in EX
    next_cycle();
    valid = 1'b1; alu_ctrl = OP_ADD; rs1 = 32'd5; rs2 = 32'd6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("add_stall", 32'(stall), 32'd0);
      check("add_busy", 32'(busy), 32'd0);
      if (i < 4) next_cycle();
    end
    next_cycle();
    valid = 1'b0;

    // MUL opcode with valid low does nothing
    alu_ctrl = OP_MUL;
    @(negedge clk);
    check("novalid_stall", 32'(stall), 32'd0);
    next_cycle();
    @(negedge clk);
    check("novalid_busy", 32'(busy), 32'd0);
    alu_ctrl = OP_ADD;

    // Small multipliers (early-termination candidates)
    do_mul("mul_123x0", 32'd123, 32'd0, 32'd0, exp_lat(32'd0));
    do_mul("mul_5x1", 32'd5, 32'd1, 32'd5, exp_lat(32'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
